// File: rtl/subservient_uart_loader.sv
// rtl/subservient_uart_loader.sv - 8N1 UART boot loader writing an image through the subservient debug Wishbone port
// Optional trailing checksum byte is enabled by defining SUBSERVIENT_LOADER_CHECKSUM_EN.
module subservient_uart_loader #(
  parameter int BAUD_DIV = 139,
  parameter int MAX_LEN  = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  output logic        o_debug_mode,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  output logic        o_done,
  output logic        o_error
);

  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [31:0] MAX_LEN_W = 32'(MAX_LEN);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] ST_LEN   = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;
`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_END   = ST_CSUM;
`else
  localparam logic [2:0] ST_END   = ST_RUN;
`endif

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]  rx_state_q, rx_state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        byte_valid_q, byte_valid_d;

  logic [2:0]  state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [1:0]  len_cnt_q, len_cnt_d;
  logic [31:0] data_cnt_q, data_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] adr_next_q, adr_next_d;
  logic        wb_stb_q, wb_stb_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic [31:0] new_len;
  logic [31:0] word;
  logic        last_byte;

  // Receiver: a falling edge is only trusted if the line is still low half a bit later.
  always_comb begin
    rx_state_d   = rx_state_q;
    baud_cnt_d   = baud_cnt_q + 16'd1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        baud_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_cnt_q == BIT_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      default: begin
        if (baud_cnt_q == BIT_LAST) begin
          baud_cnt_d   = '0;
          byte_valid_d = rx_sync_q;
          rx_state_d   = RX_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    len_cnt_d  = len_cnt_q;
    data_cnt_d = data_cnt_q;
    asm_d      = asm_q;
    adr_next_d = adr_next_q;
    wb_stb_d   = wb_stb_q;
    wb_adr_d   = wb_adr_q;
    wb_dat_d   = wb_dat_q;
    wb_sel_d   = wb_sel_q;
`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    new_len    = {shift_q, len_q[31:8]};
    last_byte  = (data_cnt_q + 32'd1) == len_q;
    word       = (data_cnt_q[1:0] == 2'd0) ? {24'd0, shift_q}
                 : (asm_q | ({24'd0, shift_q} << {data_cnt_q[1:0], 3'b000}));

    if (wb_stb_q && i_wb_ack) wb_stb_d = 1'b0;

    case (state_q)
      ST_LEN: begin
        if (byte_valid_q) begin
          len_d     = new_len;
          len_cnt_d = len_cnt_q + 2'd1;
          if (len_cnt_q == 2'd3) begin
            if (new_len == 32'd0)         state_d = ST_END;
            else if (new_len > MAX_LEN_W) state_d = ST_ERROR;
            else                          state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_valid_q) begin
          asm_d      = word;
          data_cnt_d = data_cnt_q + 32'd1;
`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
          csum_d     = csum_q + shift_q;
`endif
          if (data_cnt_q[1:0] == 2'd3 || last_byte) begin
            // An ack in this same cycle frees the buffer, so only an unacked strobe is an overrun.
            if (wb_stb_q && !i_wb_ack) begin
              state_d  = ST_ERROR;
              wb_stb_d = 1'b0;
            end else begin
              wb_stb_d   = 1'b1;
              wb_adr_d   = adr_next_q;
              wb_dat_d   = word;
              adr_next_d = adr_next_q + 32'd4;
              case (data_cnt_q[1:0])
                2'd0:    wb_sel_d = 4'b0001;
                2'd1:    wb_sel_d = 4'b0011;
                2'd2:    wb_sel_d = 4'b0111;
                default: wb_sel_d = 4'b1111;
              endcase
              if (last_byte) state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (!wb_stb_q || i_wb_ack) state_d = ST_END;
      end
`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (byte_valid_q) state_d = (shift_q == csum_q) ? ST_RUN : ST_ERROR;
      end
`endif
      ST_RUN: begin
        wb_stb_d = 1'b0;
      end
      default: begin
        state_d  = ST_ERROR;
        wb_stb_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      state_q      <= ST_LEN;
      len_q        <= '0;
      len_cnt_q    <= '0;
      data_cnt_q   <= '0;
      asm_q        <= '0;
      adr_next_q   <= '0;
      wb_stb_q     <= 1'b0;
      wb_adr_q     <= '0;
      wb_dat_q     <= '0;
      wb_sel_q     <= '0;
`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      rx_meta_q    <= i_rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      state_q      <= state_d;
      len_q        <= len_d;
      len_cnt_q    <= len_cnt_d;
      data_cnt_q   <= data_cnt_d;
      asm_q        <= asm_d;
      adr_next_q   <= adr_next_d;
      wb_stb_q     <= wb_stb_d;
      wb_adr_q     <= wb_adr_d;
      wb_dat_q     <= wb_dat_d;
      wb_sel_q     <= wb_sel_d;
`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign o_debug_mode = (state_q != ST_RUN);
  assign o_done       = (state_q == ST_RUN);
  assign o_error      = (state_q == ST_ERROR);
  assign o_wb_stb     = wb_stb_q;
  assign o_wb_adr     = wb_adr_q;
  assign o_wb_dat     = wb_dat_q;
  assign o_wb_sel     = wb_sel_q;
  assign o_wb_we      = 1'b1;

endmodule

// File: tb/tb_subservient_uart_loader.sv
// tb/tb_subservient_uart_loader.sv - scoreboard bench for subservient_uart_loader
module tb_subservient_uart_loader;
  localparam int BD = 8;

  logic        clk = 1'b0;
  logic        rst, rx, ack;
  logic        debug_mode, wb_we, wb_stb, done, error;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  ack_en = 1'b1;
  bit  spur_en = 1'b0;
  int  ack_delay = 0;
  int  stb_cycles = 0;

  always #5 clk = ~clk;

  subservient_uart_loader #(.BAUD_DIV(BD), .MAX_LEN(512)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx),
    .o_debug_mode(debug_mode), .o_wb_adr(wb_adr), .o_wb_dat(wb_dat),
    .o_wb_sel(wb_sel), .o_wb_we(wb_we), .o_wb_stb(wb_stb), .i_wb_ack(ack),
    .o_done(done), .o_error(error)
  );

  // Wishbone slave: acks after ack_delay cycles, optionally throws in stray acks while idle.
  initial begin
    int waited;
    waited = 0;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack) ack = 1'b0;
      else if (wb_stb && ack_en) begin
        if (waited >= ack_delay) begin
          ack = 1'b1;
          waited = 0;
        end else waited++;
      end else if (!wb_stb && spur_en && $urandom_range(0, 7) == 0) ack = 1'b1;
    end
  end

  // Monitor: every accepted write is popped against the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #1;
      if (wb_stb) stb_cycles++;
      if (wb_stb && ack) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wb_write: unexpected adr=%h dat=%h sel=%h", wb_adr, wb_dat, wb_sel);
        end else begin
          e = exp_q.pop_front();
          if (wb_adr !== e.adr || wb_dat !== e.dat || wb_sel !== e.sel || wb_we !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL wb_write: got adr=%h dat=%h sel=%h we=%b done=%b, expected adr=%h dat=%h sel=%h we=1 done=0",
                     wb_adr, wb_dat, wb_sel, wb_we, done, e.adr, e.dat, e.sel);
          end
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("rst_stb", wb_stb, 0);
    check("rst_adr_dat_sel", {wb_adr ^ wb_dat, 28'd0, wb_sel}, 0);
    check("rst_status", {debug_mode, done, error}, 3'b100);
    rst = 1'b0;
    stb_cycles = 0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = stop;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (2 * BD) @(negedge clk);
  endtask

  task automatic glitch();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BD) @(negedge clk);
  endtask

  // Reference model: the image split into 4-byte little-endian words at consecutive addresses.
  task automatic expect_writes(input logic [7:0] p[$]);
    wr_t e;
    int  cnt;
    for (int w = 0; w * 4 < p.size(); w++) begin
      cnt = (p.size() - w * 4 >= 4) ? 4 : p.size() - w * 4;
      e.adr = 32'(w * 4);
      e.dat = 32'd0;
      for (int k = 0; k < cnt; k++) e.dat[8*k +: 8] = p[w*4 + k];
      e.sel = 4'((1 << cnt) - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic load(input logic [7:0] p[$], input logic [31:0] len, input logic [7:0] csum_adj);
    logic [7:0] s;
    s = csum_adj;
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b1);
    foreach (p[i]) begin
      send_byte(p[i], 1'b1);
      s = s + p[i];
    end
`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
    send_byte(s, 1'b1);
`endif
  endtask

  task automatic wait_end(input int bound);
    int c;
    c = 0;
    while (!(done || error) && c < bound) begin
      @(negedge clk);
      c++;
    end
    if (c >= bound) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_end: no done/error within %0d cycles", bound);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_outcome(input string name, input logic ok);
    check({name, "_status"}, {debug_mode, done, error}, ok ? 3'b010 : 3'b101);
    check({name, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic image_test(input string name, input logic [7:0] p[$], input logic [7:0] csum_adj, input logic ok);
    do_reset();
    expect_writes(p);
    load(p, 32'(p.size()), csum_adj);
    wait_end(20 * BD * 12);
    expect_outcome(name, ok);
  endtask

  initial begin
    logic [7:0] p[$];
    int bad;
    int n;
    int seen;

    // Idle line after reset: loader stays quiet and keeps the core halted.
    do_reset();
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (debug_mode !== 1'b1 || wb_stb !== 1'b0 || done !== 1'b0 || error !== 1'b0) bad++;
    end
    check("idle_quiet_cycles_bad", bad, 0);

    p = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    image_test("two_words", p, 8'h00, 1'b1);
    seen = stb_cycles;
    send_byte(8'h55, 1'b1);
    repeat (2 * BD) @(negedge clk);
    check("run_ignores_rx", {stb_cycles - seen, 29'd0, done, debug_mode, error}, {32'd0, 3'b100});

    p = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    image_test("partial_word", p, 8'h00, 1'b1);

    p = '{};
    image_test("zero_len", p, 8'h00, 1'b1);

    // Over-long length is rejected before any strobe.
    do_reset();
    p = '{};
    load(p, 32'h0000_0201, 8'h00);
    wait_end(2000);
    check("too_long_status", {debug_mode, done, error}, 3'b101);
    check("too_long_no_stb", stb_cycles, 0);

    // Stalled slave: the second completed word must trip the overrun error.
    do_reset();
    ack_en = 1'b0;
    p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    load(p, 32'd8, 8'h00);
    wait_end(2000);
    check("overrun_status", {debug_mode, done, error, wb_stb}, 4'b1010);
    ack_en = 1'b1;

    // Glitch and framing-error bytes ahead of the image must not be accepted.
    do_reset();
    p = '{8'h11, 8'h22, 8'h33};
    expect_writes(p);
    glitch();
    send_byte(8'hA5, 1'b0);
    glitch();
    load(p, 32'd3, 8'h00);
    wait_end(2000);
    expect_outcome("glitch_framing", 1'b1);

`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
    p = '{8'h01, 8'h02, 8'h03, 8'h04};
    image_test("csum_good", p, 8'h00, 1'b1);
    image_test("csum_bad", p, 8'h01, 1'b0);
`endif

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 24);
      p = '{};
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      ack_delay = $urandom_range(0, 5);
      spur_en = 1'($urandom_range(0, 1));
      image_test("random", p, 8'h00, 1'b1);
    end
    spur_en = 1'b0;
    ack_delay = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
